// File: rtl/zdram_port.sv
// DRAM slot port: arbitrates each 4-clock slot between the CPU and video fetch.
// It issues one DRAM access per granted slot and returns CPU read data through a register.
module zdram_port #(
   parameter int STARVE_LIM = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c0,
   input  logic        c1,
   input  logic        c2,
   input  logic        c3,
   input  logic        cpu_req,
   input  logic [20:0] cpu_addr,
   input  logic        cpu_rnw,
   input  logic        cpu_wrbsel,
   input  logic [7:0]  cpu_wrdata,
   output logic [15:0] cpu_rddata,
   output logic        cpu_next,
   output logic        cpu_strobe,
   output logic        cpu_latch,
   input  logic        vid_req,
   input  logic [20:0] vid_addr,
   output logic        vid_next,
   output logic        vid_strobe,
   output logic        dram_req,
   output logic [20:0] dram_addr,
   output logic        dram_rnw,
   output logic [1:0]  dram_bsel,
   output logic [15:0] dram_wrdata,
   input  logic [15:0] dram_rddata
);

   // state      | meaning
   // OWN_IDLE   | current slot carries no access
   // OWN_CPU_RD | current slot is a CPU read
   // OWN_CPU_WR | current slot is a CPU byte write
   // OWN_VID    | current slot is a video fetch
   typedef enum logic [1:0] {
      OWN_IDLE   = 2'd0,
      OWN_CPU_RD = 2'd1,
      OWN_CPU_WR = 2'd2,
      OWN_VID    = 2'd3
   } owner_t;

   owner_t     owner;
   owner_t     owner_nxt;
   logic [1:0] wait_cnt;
   logic [1:0] wait_nxt;
   logic       starve;
   logic       cpu_grant;
   logic       vid_grant;
   logic       issued;

   assign starve    = ({30'd0, wait_cnt} >= 32'(STARVE_LIM));
   assign cpu_next  = !vid_req || starve;
   assign vid_next  = vid_req && !(cpu_req && starve);
   assign cpu_grant = cpu_req && cpu_next;
   assign vid_grant = vid_next && !cpu_grant;

   always_ff @(posedge clk) begin
      if (rst) owner <= OWN_IDLE;
      else     owner <= owner_nxt;
   end

   always_comb begin
      owner_nxt = owner;
      wait_nxt  = wait_cnt;
      if (c3) begin
         if (cpu_grant) begin
            owner_nxt = cpu_rnw ? OWN_CPU_RD : OWN_CPU_WR;
            wait_nxt  = 2'd0;
         end else if (vid_grant) begin
            owner_nxt = OWN_VID;
            if (!cpu_req)              wait_nxt = 2'd0;
            else if (wait_cnt != 2'd3) wait_nxt = wait_cnt + 2'd1;
         end else begin
            owner_nxt = OWN_IDLE;
            if (!cpu_req) wait_nxt = 2'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= 2'd0;
         dram_req    <= 1'b0;
         dram_addr   <= 21'd0;
         dram_rnw    <= 1'b1;
         dram_bsel   <= 2'b00;
         dram_wrdata <= 16'd0;
         issued      <= 1'b0;
         cpu_strobe  <= 1'b0;
         vid_strobe  <= 1'b0;
         cpu_latch   <= 1'b0;
         cpu_rddata  <= 16'd0;
      end else begin
         dram_req   <= c3 && (cpu_grant || vid_grant);
         // Strobes fire on c2 only for a slot whose request actually went out on c0.
         if (c0) issued <= dram_req;
         cpu_strobe <= c1 && issued && (owner == OWN_CPU_RD);
         vid_strobe <= c1 && issued && (owner == OWN_VID);
         if (cpu_strobe) begin
            cpu_rddata <= dram_rddata;
            cpu_latch  <= 1'b1;
         end
         if (c3) begin
            wait_cnt <= wait_nxt;
            if (cpu_grant || vid_grant) begin
               dram_addr   <= cpu_grant ? cpu_addr : vid_addr;
               dram_rnw    <= cpu_grant ? cpu_rnw : 1'b1;
               dram_wrdata <= {cpu_wrdata, cpu_wrdata};
               if (cpu_grant && !cpu_rnw) dram_bsel <= cpu_wrbsel ? 2'b10 : 2'b01;
               else                       dram_bsel <= 2'b11;
            end
            if (cpu_grant) cpu_latch <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_zdram_port.sv
// Bench for zdram_port: directed slot scenarios with literal expectations, then randomized traffic.
// A slot-level reference model is compared against the DUT outputs on every clock.
module tb_zdram_port;
   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        rst, c0, c1, c2, c3;
   logic        cpu_req, cpu_rnw, cpu_wrbsel, vid_req;
   logic [20:0] cpu_addr, vid_addr;
   logic [7:0]  cpu_wrdata;
   logic [15:0] dram_rddata;
   logic [15:0] cpu_rddata, dram_wrdata;
   logic        cpu_next, cpu_strobe, cpu_latch, vid_next, vid_strobe;
   logic        dram_req, dram_rnw;
   logic [20:0] dram_addr;
   logic [1:0]  dram_bsel;

   always #5 clk = ~clk;

   zdram_port #(.STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
      .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata), .cpu_rddata(cpu_rddata),
      .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_next(vid_next), .vid_strobe(vid_strobe),
      .dram_req(dram_req), .dram_addr(dram_addr), .dram_rnw(dram_rnw),
      .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
   );

   int checks = 0;
   int failures = 0;
   int ph = 0;
   bit chk_en = 0;

   // Reference model: owner 0 idle, 1 cpu read, 2 cpu write, 3 video.
   int          m_owner = 0;
   int          m_wait = 0;
   logic [20:0] m_addr = '0;
   logic        m_rnw = 1'b1;
   logic [1:0]  m_bsel = '0;
   logic [15:0] m_wd = '0;
   logic [15:0] m_rd = '0;
   bit          m_wd_known = 1;
   bit          m_latch = 0;
   bit          e_dreq = 0, e_cs = 0, e_vs = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive_phase();
      c0 = (ph == 0); c1 = (ph == 1); c2 = (ph == 2); c3 = (ph == 3);
   endtask

   task automatic compare();
      bit starve;
      if (!chk_en) return;
      starve = (m_wait >= LIM);
      chk("cpu_next", cpu_next, !vid_req || starve);
      chk("vid_next", vid_next, vid_req && !(cpu_req && starve));
      chk("dram_req", dram_req, e_dreq);
      chk("cpu_strobe", cpu_strobe, e_cs);
      chk("vid_strobe", vid_strobe, e_vs);
      chk("cpu_latch", cpu_latch, m_latch);
      chk("cpu_rddata", cpu_rddata, m_rd);
      chk("dram_addr", dram_addr, m_addr);
      chk("dram_rnw", dram_rnw, m_rnw);
      chk("dram_bsel", dram_bsel, m_bsel);
      if (m_wd_known) chk("dram_wrdata", dram_wrdata, m_wd);
   endtask

   task automatic model_step();
      bit starve, cw, vw;
      int nph;
      starve = (m_wait >= LIM);
      if (rst) begin
         m_owner = 0; m_wait = 0; m_latch = 0; m_rd = '0;
         m_addr = '0; m_bsel = '0; m_wd = '0; m_rnw = 1'b1; m_wd_known = 1;
      end else begin
         if (ph == 2 && m_owner == 1) begin
            m_rd = dram_rddata;
            m_latch = 1;
         end
         if (ph == 3) begin
            cw = cpu_req && (!vid_req || starve);
            vw = !cw && vid_req && !(cpu_req && starve);
            if (cw) begin
               m_owner = cpu_rnw ? 1 : 2;
               m_addr = cpu_addr; m_rnw = cpu_rnw;
               m_bsel = cpu_rnw ? 2'b11 : (cpu_wrbsel ? 2'b10 : 2'b01);
               m_wd = {cpu_wrdata, cpu_wrdata}; m_wd_known = !cpu_rnw;
               m_latch = 0; m_wait = 0;
            end else if (vw) begin
               m_owner = 3; m_addr = vid_addr; m_rnw = 1'b1; m_bsel = 2'b11;
               m_wd_known = 0;
               if (cpu_req) m_wait = (m_wait < 3) ? m_wait + 1 : 3;
            end else begin
               m_owner = 0;
            end
            if (!cpu_req) m_wait = 0;
         end
      end
      nph = (ph + 1) % 4;
      e_dreq = (nph == 0) && (m_owner != 0);
      e_cs   = (nph == 2) && (m_owner == 1);
      e_vs   = (nph == 2) && (m_owner == 3);
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
      #1;
      ph = (ph + 1) % 4;
      drive_phase();
   endtask

   int vs_cnt, cs_cnt;

   initial begin
      rst = 1; cpu_req = 0; cpu_rnw = 1; cpu_wrbsel = 0; vid_req = 0;
      cpu_addr = '0; vid_addr = '0; cpu_wrdata = '0; dram_rddata = '0;
      drive_phase();
      repeat (4) tick();
      chk_en = 1;
      chk("rst_dram_rnw", dram_rnw, 1'b1);
      chk("rst_dram_bsel", dram_bsel, 2'b00);
      chk("rst_cpu_rddata", cpu_rddata, 16'h0);
      rst = 0;
      while (ph != 3) tick();

      // CPU read with no video contention
      cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h12345; vid_req = 0;
      #1 chk("rd_cpu_next", cpu_next, 1'b1);
      tick();
      chk("rd_dram_req", dram_req, 1'b1);
      chk("rd_dram_addr", dram_addr, 21'h12345);
      chk("rd_dram_bsel", dram_bsel, 2'b11);
      cpu_req = 0; cpu_addr = 21'h0F0F0;
      tick();
      tick();
      chk("rd_cpu_strobe", cpu_strobe, 1'b1);
      dram_rddata = 16'hBEEF;
      tick();
      chk("rd_cpu_rddata", cpu_rddata, 16'hBEEF);
      chk("rd_cpu_latch", cpu_latch, 1'b1);
      chk("rd_dram_addr_held", dram_addr, 21'h12345);

      // CPU high-byte write
      cpu_req = 1; cpu_rnw = 0; cpu_wrbsel = 1; cpu_wrdata = 8'hA5; cpu_addr = 21'h00777;
      tick();
      chk("wr_dram_rnw", dram_rnw, 1'b0);
      chk("wr_dram_bsel", dram_bsel, 2'b10);
      chk("wr_dram_wrdata", dram_wrdata, 16'hA5A5);
      chk("wr_cpu_latch_clr", cpu_latch, 1'b0);
      cpu_req = 0; cpu_wrdata = 8'h3C; dram_rddata = 16'h1234;
      tick(); tick();
      chk("wr_no_strobe", cpu_strobe, 1'b0);
      tick();
      chk("wr_rddata_kept", cpu_rddata, 16'hBEEF);

      // both requesting: video x3, CPU, video
      cpu_req = 1; cpu_rnw = 1; vid_req = 1; vid_addr = 21'h1ABCD;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("starve_cpu_next", cpu_next, k == 3);
         chk("starve_vid_next", vid_next, k != 3);
         repeat (4) tick();
      end

      // video only for four slots
      cpu_req = 0;
      vs_cnt = 0; cs_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("vid_only_cpu_next", cpu_next, 1'b0);
         for (int j = 0; j < 4; j++) begin
            tick();
            if (vid_strobe) begin
               vs_cnt++;
               chk("vid_strobe_phase", ph, 2);
            end
            if (cpu_strobe) cs_cnt++;
         end
      end
      chk("vid_strobe_count", vs_cnt, 4);
      chk("vid_only_cpu_strobes", cs_cnt, 0);

      // reset on c1 of a CPU read slot
      vid_req = 0; cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h05555;
      tick();
      chk("rstmid_dram_req", dram_req, 1'b1);
      cpu_req = 0;
      tick();
      rst = 1;
      tick();
      chk("rstmid_no_strobe", cpu_strobe, 1'b0);
      chk("rstmid_rddata", cpu_rddata, 16'h0);
      chk("rstmid_latch", cpu_latch, 1'b0);
      rst = 0; cpu_req = 1; cpu_addr = 21'h0AAAA;
      tick();
      #1 chk("rstmid_cpu_next", cpu_next, 1'b1);
      tick();
      chk("rstmid_regrant", dram_req, 1'b1);
      chk("rstmid_regrant_addr", dram_addr, 21'h0AAAA);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
         if ($urandom_range(0, 4) == 0) vid_req = ~vid_req;
         rst = ($urandom_range(0, 149) == 0);
         cpu_rnw = $urandom_range(0, 1) == 1;
         cpu_wrbsel = $urandom_range(0, 1) == 1;
         cpu_wrdata = 8'($urandom);
         cpu_addr = 21'($urandom);
         vid_addr = 21'($urandom);
         dram_rddata = 16'($urandom);
         tick();
      end
      rst = 0; cpu_req = 0; vid_req = 0;
      repeat (8) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/zdram_port.md
ZDRAM_PORT -- requirements
Module: zdram_port

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 3: the number of consecutive CPU-losing slots after which the CPU wins arbitration.
REQ-002 SHALL have port clk  in  1  system clock; sole clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports c0,c1,c2,c3  in  1 each  one-hot rotating slot-phase strobes, order c0->c1->c2->c3.
REQ-005 SHALL have port cpu_req  in  1  CPU DRAM request level from the memory manager.
REQ-006 SHALL have port cpu_addr  in  21  CPU word address.
REQ-007 SHALL have port cpu_rnw  in  1  1 = read, 0 = write.
REQ-008 SHALL have port cpu_wrbsel  in  1  write byte select: 0 = low byte, 1 = high byte.
REQ-009 SHALL have port cpu_wrdata  in  8  CPU write byte.
REQ-010 SHALL have port cpu_rddata  out  16  registered read word.
REQ-011 SHALL have port cpu_next  out  1  next slot is available to the CPU; sampled with c3.
REQ-012 SHALL have port cpu_strobe  out  1  one-clock pulse marking a valid CPU read word (cache write enable).
REQ-013 SHALL have port cpu_latch  out  1  cpu_rddata holds the most recent CPU read word.
REQ-014 SHALL have port vid_req  in  1  video fetch request level.
REQ-015 SHALL have port vid_addr  in  21  video word address.
REQ-016 SHALL have port vid_next  out  1  next slot is granted to video; meaningful on c3.
REQ-017 SHALL have port vid_strobe  out  1  one-clock pulse marking a valid video word on dram_rddata.
REQ-018 SHALL have port dram_req  out  1  DRAM access start, one clock wide, on c0.
REQ-019 SHALL have port dram_addr  out  21  registered DRAM word address.
REQ-020 SHALL have port dram_rnw  out  1  DRAM direction: 1 = read.
REQ-021 SHALL have port dram_bsel  out  2  byte enables: [0] = low byte, [1] = high byte.
REQ-022 SHALL have port dram_wrdata  out  16  write word.
REQ-023 SHALL have port dram_rddata  in  16  read word; valid on c2 of the slot issued at the preceding c0.

Function
REQ-024 SHALL treat one slot as 4 clocks (c0..c3); arbitration for slot N+1 SHALL occur on the c3 clock of slot N.
REQ-025 SHALL compute starve = (wait_cnt >= STARVE_LIM); SHALL drive cpu_next = !vid_req || starve combinationally, and vid_next = vid_req && !(cpu_req && starve).
REQ-026 SHALL grant the CPU on c3 when cpu_req && cpu_next; SHALL grant video on c3 when vid_next && !(CPU grant); SHALL make the next slot idle otherwise.
REQ-027 On a grant, SHALL register owner, address, rnw, bsel and wrdata at that c3 clock.
REQ-028 SHALL hold the registered values stable for the whole next slot, independent of later input changes.
REQ-029 SHALL pulse dram_req high on c0 of a granted slot only; idle slots SHALL keep dram_req = 0.
REQ-030 CPU write: dram_rnw = 0; dram_bsel = 2'b01 if cpu_wrbsel = 0, else 2'b10; dram_wrdata = {cpu_wrdata, cpu_wrdata}.
REQ-031 CPU read and video: dram_rnw = 1, dram_bsel = 2'b11.
REQ-032 CPU read slot, c2 clock: SHALL pulse cpu_strobe for exactly 1 clock and capture dram_rddata into cpu_rddata on that clock.
REQ-033 CPU write slots SHALL never pulse cpu_strobe or alter cpu_rddata.
REQ-034 SHALL set cpu_latch to 1 on the clock after a cpu_strobe pulse and clear it on the next CPU grant (read or write).
REQ-035 Video slot, c2 clock: SHALL pulse vid_strobe for exactly 1 clock; video data SHALL NOT be registered.
REQ-036 wait_cnt SHALL be a 2-bit counter updated on c3 and saturating at 3.
REQ-037 On c3: CPU grant -> wait_cnt = 0; cpu_req && video grant -> wait_cnt + 1; !cpu_req -> wait_cnt = 0.
REQ-038 A cpu_req rising on a c3 clock SHALL be arbitrated on that same c3 with no extra latency.
REQ-039 With no requests, every slot SHALL be idle with no output pulses.

Reset
REQ-040 While rst = 1, SHALL force: owner = idle, wait_cnt = 0, dram_req = cpu_strobe = vid_strobe = cpu_latch = 0, cpu_rddata = 0, dram_addr = 0, dram_bsel = 0, dram_wrdata = 0, dram_rnw = 1.
REQ-041 rst asserted mid-slot SHALL cancel the remaining strobes of that slot; the first grant after release SHALL occur on the first c3 with rst = 0.

Verification
REQ-042 CPU read, cpu_addr = 0x12345, vid_req = 0 -> cpu_next = 1 at c3; next c0: dram_req = 1, dram_addr = 0x12345, dram_bsel = 11; c2: dram_rddata = 0xBEEF -> cpu_strobe pulse, cpu_rddata = 0xBEEF; cpu_latch = 1 from c3.
REQ-043 CPU write, cpu_wrbsel = 1, cpu_wrdata = 0xA5 -> dram_rnw = 0, dram_bsel = 10, dram_wrdata = 0xA5A5; no cpu_strobe; cpu_rddata unchanged.
REQ-044 vid_req and cpu_req both held high -> video wins 3 slots, CPU wins the 4th (cpu_next = 1, vid_next = 0), then video wins again.
REQ-045 vid_req only, 4 slots -> 4 vid_strobe pulses, each on c2; cpu_strobe stays 0; wait_cnt stays 0.
REQ-046 rst pulse on c1 of a CPU read slot -> no cpu_strobe on the following c2; cpu_rddata = 0; cpu_latch = 0; normal grant resumes at the next c3.
